pwm_duty_capture: RTL

//   Input-capture block, the decoder for the on-chip PWM generator: measures an

---
 rtl/pwm_duty_capture_if.sv | 24 ++
 rtl/pwm_duty_capture.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pwm_duty_capture_if.sv
// Measurement bus of the PWM duty-capture block: enable and raw pin in,
// measured duty/period/status out.
interface pwm_duty_capture_if #(
  parameter int PERIOD_W = 10
);
  logic                ena;
  logic                pwm_in;
  logic [7:0]          duty;
  logic [PERIOD_W-1:0] period;
  logic                duty_valid;
  logic                stuck;

  // Driver side: supplies enable and pin, observes measurements
  modport master (
    output ena, pwm_in,
    input  duty, period, duty_valid, stuck
  );

  // Capture block side
  modport slave (
    input  ena, pwm_in,
    output duty, period, duty_valid, stuck
  );
endinterface

// File: rtl/pwm_duty_capture.sv
// PWM input capture: measures high time (duty, clamped to 8 bits) and
// rising-edge-to-rising-edge period of an asynchronous PWM pin. A missing
// rising edge for 2**PERIOD_W-1 cycles flags the input as stuck.
// Optional build macro PWM_CAP_AVG_EN: duty is the average of the last four
// captures and duty_valid is held off until four captures are available.
module pwm_duty_capture #(
  parameter int PERIOD_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  pwm_duty_capture_if.slave cap
);

  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;
  localparam logic [PERIOD_W-1:0] CNT_PRE = CNT_MAX - 1'b1;
  localparam logic [PERIOD_W-1:0] CNT_ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};
  localparam logic [PERIOD_W-1:0] DUTY_SAT = PERIOD_W'(255);

  typedef enum logic {S_IDLE = 1'b0, S_MEASURE = 1'b1} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_meta, r_sync, r_prev;
  logic [PERIOD_W-1:0] r_period_cnt, w_period_cnt_nxt;
  logic [PERIOD_W-1:0] r_high_cnt, w_high_cnt_nxt;
  logic [7:0]          r_duty, w_duty_nxt;
  logic [PERIOD_W-1:0] r_period, w_period_nxt;
  logic                r_valid, w_valid_nxt;
  logic                r_stuck, w_stuck_nxt;

  logic                w_rise;
  logic                w_timeout;
  logic                w_cap;
  logic [PERIOD_W-1:0] w_pc_inc, w_hc_inc;
  logic [7:0]          w_hi_clamp;

  // Pin synchronizer plus one-cycle-delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= cap.pwm_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign w_rise     = r_sync & ~r_prev;
  assign w_pc_inc   = (r_period_cnt == CNT_MAX) ? CNT_MAX : r_period_cnt + 1'b1;
  assign w_hc_inc   = (r_high_cnt == CNT_MAX) ? CNT_MAX : r_high_cnt + PERIOD_W'(r_sync);
  assign w_hi_clamp = (r_high_cnt > DUTY_SAT) ? 8'hFF : r_high_cnt[7:0];
  // Fires on the cycle the period counter would reach saturation; once
  // saturated it never fires again, so a dead input reports exactly once.
  assign w_timeout  = cap.ena & ~w_rise & (r_period_cnt == CNT_PRE);
  assign w_cap      = cap.ena & w_rise & (r_state == S_MEASURE);

`ifdef PWM_CAP_AVG_EN
  logic [2:0][7:0] r_hist;
  logic [2:0]      r_hist_cnt;
  logic [9:0]      w_sum;
  logic [7:0]      w_avg;
  logic            w_avg_ok;

  // Window = this capture plus the three previous ones
  assign w_sum    = 10'(w_hi_clamp) + 10'(r_hist[0]) + 10'(r_hist[1]) + 10'(r_hist[2]);
  assign w_avg    = 8'(w_sum >> 2);
  assign w_avg_ok = (r_hist_cnt >= 3'd3);

  // Capture history; emptied whenever the FSM falls back to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist     <= '0;
      r_hist_cnt <= '0;
    end else if (!cap.ena || w_timeout) begin
      r_hist     <= '0;
      r_hist_cnt <= '0;
    end else if (w_cap) begin
      r_hist     <= {r_hist[1:0], w_hi_clamp};
      r_hist_cnt <= (r_hist_cnt == 3'd4) ? 3'd4 : r_hist_cnt + 3'd1;
    end
  end
`endif

  // Next-state, counters and output updates
  always_comb begin
    w_state_nxt      = r_state;
    w_period_cnt_nxt = w_pc_inc;
    w_high_cnt_nxt   = r_high_cnt;
    w_duty_nxt       = r_duty;
    w_period_nxt     = r_period;
    w_valid_nxt      = 1'b0;
    w_stuck_nxt      = r_stuck;
    if (!cap.ena) begin
      w_state_nxt      = S_IDLE;
      w_period_cnt_nxt = '0;
      w_high_cnt_nxt   = '0;
    end else if (w_rise) begin
      // A rise always restarts the measurement, even on a timeout cycle
      w_state_nxt      = S_MEASURE;
      w_period_cnt_nxt = CNT_ONE;
      w_high_cnt_nxt   = CNT_ONE;
      w_stuck_nxt      = 1'b0;
      if (w_cap) begin
`ifdef PWM_CAP_AVG_EN
        if (w_avg_ok) begin
          w_duty_nxt   = w_avg;
          w_period_nxt = r_period_cnt;
          w_valid_nxt  = 1'b1;
        end
`else
        w_duty_nxt   = w_hi_clamp;
        w_period_nxt = r_period_cnt;
        w_valid_nxt  = 1'b1;
`endif
      end
    end else if (w_timeout) begin
      w_state_nxt    = S_IDLE;
      w_high_cnt_nxt = '0;
      w_stuck_nxt    = 1'b1;
      w_duty_nxt     = r_sync ? 8'hFF : 8'h00;
      w_period_nxt   = CNT_MAX;
      w_valid_nxt    = 1'b1;
    end else if (r_state == S_MEASURE) begin
      w_high_cnt_nxt = w_hc_inc;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_period_cnt <= '0;
      r_high_cnt   <= '0;
      r_duty       <= '0;
      r_period     <= '0;
      r_valid      <= 1'b0;
      r_stuck      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_period_cnt <= w_period_cnt_nxt;
      r_high_cnt   <= w_high_cnt_nxt;
      r_duty       <= w_duty_nxt;
      r_period     <= w_period_nxt;
      r_valid      <= w_valid_nxt;
      r_stuck      <= w_stuck_nxt;
    end
  end

  assign cap.duty       = r_duty;
  assign cap.period     = r_period;
  assign cap.duty_valid = r_valid;
  assign cap.stuck      = r_stuck;

endmodule
